// File: rtl/reg_bank_param.sv
// Parametrised register bank: two registered read ports with constant injection,
// one write port, optional zero register and a multi-cycle clear sequencer.
// Optional write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module reg_bank_param #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             regwe,
  input  logic             selwreg,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] aluin,
  input  logic [AW-1:0]    endwreg,
  input  logic [AW-1:0]    seloutA,
  input  logic [AW-1:0]    seloutB,
  input  logic             selcnstA,
  input  logic             selcnstB,
  input  logic [WIDTH-1:0] cnstA,
  input  logic [WIDTH-1:0] cnstB,
  input  logic             enrregA,
  input  logic             enrregB,
  input  logic             clr_req,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              done_nxt;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [WIDTH-1:0]  wr_data, rd_a, rd_b;
  logic              wr_en;

  assign wr_data = selwreg ? aluin : inA;
  // Writes are dropped while clearing and, with a zero register, to address 0.
  assign wr_en   = (state == IDLE) && regwe && !((ZERO_R0 != 0) && (endwreg == '0));
  assign busy    = (state == CLEAR);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  // NOTE: the array is reset because the bank must read as zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[endwreg] <= wr_data;
    end
  end

  always_comb begin
    rd_a = ((ZERO_R0 != 0) && (seloutA == '0)) ? '0 : regs[seloutA];
    rd_b = ((ZERO_R0 != 0) && (seloutB == '0)) ? '0 : regs[seloutB];
`ifdef REGBANK_BYPASS_EN
    if (wr_en && (seloutA == endwreg)) rd_a = wr_data;
    if (wr_en && (seloutB == endwreg)) rd_b = wr_data;
`endif
  end

  // Constant selection overrides both the array and any forwarded data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outA <= '0;
      outB <= '0;
    end else begin
      if (enrregA) outA <= selcnstA ? cnstA : rd_a;
      if (enrregB) outB <= selcnstB ? cnstB : rd_b;
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: one instance with a zero register and
// one without, driven by a shared table of directed vectors plus clear/reset sequences.
module tb_reg_bank_param;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        regwe, selwreg, selcnstA, selcnstB, enrregA, enrregB, clr_req;
  logic [31:0] inA, aluin, cnstA, cnstB;
  logic [3:0]  endwreg, seloutA, seloutB;
  logic [31:0] outA, outB, outA_nz, outB_nz;
  logic        busy, clr_done, busy_nz, clr_done_nz;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  reg_bank_param #(.WIDTH(32), .NREGS(16), .ZERO_R0(1)) dut (
    .clock(clock), .reset(reset), .regwe(regwe), .selwreg(selwreg), .inA(inA),
    .aluin(aluin), .endwreg(endwreg), .seloutA(seloutA), .seloutB(seloutB),
    .selcnstA(selcnstA), .selcnstB(selcnstB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .clr_req(clr_req),
    .outA(outA), .outB(outB), .busy(busy), .clr_done(clr_done)
  );

  reg_bank_param #(.WIDTH(32), .NREGS(16), .ZERO_R0(0)) dut_nz (
    .clock(clock), .reset(reset), .regwe(regwe), .selwreg(selwreg), .inA(inA),
    .aluin(aluin), .endwreg(endwreg), .seloutA(seloutA), .seloutB(seloutB),
    .selcnstA(selcnstA), .selcnstB(selcnstB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .clr_req(clr_req),
    .outA(outA_nz), .outB(outB_nz), .busy(busy_nz), .clr_done(clr_done_nz)
  );

  typedef struct {
    logic        regwe, selwreg;
    logic [31:0] ina, aluin;
    logic [3:0]  endwreg, sela, selb;
    logic        csa, csb;
    logic [31:0] ca, cb;
    logic        ena, enb;
    logic [31:0] exp_a, exp_b, exp_a_nz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    regwe = 0; selwreg = 0; inA = '0; aluin = '0; endwreg = '0;
    seloutA = '0; seloutB = '0; selcnstA = 0; selcnstB = 0;
    cnstA = '0; cnstB = '0; enrregA = 0; enrregB = 0; clr_req = 0;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    idle_inputs();
    regwe = 1; endwreg = addr; inA = data;
    step();
    regwe = 0;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    bit seen;

    idle_inputs();
    #2 reset = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outA", outA, '0);
    check("reset_outB", outB, '0);
    check("reset_busy", 32'(busy), '0);
    check("reset_clr_done", 32'(clr_done), '0);
    reset = 1;
    step();

    // regwe selwreg inA aluin endw selA selB csA csB cA cB enA enB expA expB expA_nz
    vecs[0]  = '{1,0,32'hDEADBEEF,0,4'd0+5,0,0,0,0,0,0,0,0, 0,0,0};
    vecs[1]  = '{0,0,0,0,0,5,0,0,0,0,0,1,0, 32'hDEADBEEF,0,32'hDEADBEEF};
    vecs[2]  = '{1,1,0,32'h123,0,0,0,0,0,0,0,0,0, 32'hDEADBEEF,0,32'hDEADBEEF};
    vecs[3]  = '{0,0,0,0,0,0,0,0,0,0,0,1,0, 0,0,32'h123};
    vecs[4]  = '{0,0,0,0,0,0,5,0,1,0,7,0,1, 0,7,32'h123};
    vecs[5]  = '{0,0,0,0,0,0,5,0,1,0,9,0,0, 0,7,32'h123};
    vecs[6]  = '{0,0,0,0,0,5,5,1,0,32'hCAFE,9,1,1, 32'hCAFE,32'hDEADBEEF,32'hCAFE};
    vecs[7]  = '{1,0,32'h55,0,3,0,0,0,0,0,0,0,0, 32'hCAFE,32'hDEADBEEF,32'hCAFE};
    vecs[8]  = '{1,0,32'hAA,0,3,3,3,0,1,0,32'h11,1,1,
                 BYP ? 32'hAA : 32'h55, 32'h11, BYP ? 32'hAA : 32'h55};
    vecs[9]  = '{0,0,0,0,0,3,0,0,0,0,0,1,0, 32'hAA,32'h11,32'hAA};
    vecs[10] = '{1,0,32'h77,0,0,0,0,0,0,0,0,1,0, 0,32'h11, BYP ? 32'h77 : 32'h123};
    vecs[11] = '{1,0,32'hF0F0,0,15,0,15,0,0,0,0,0,1,
                 0, BYP ? 32'hF0F0 : 32'h0, BYP ? 32'h77 : 32'h123};
    vecs[12] = '{0,0,0,0,0,15,5,0,0,0,0,1,1, 32'hF0F0,32'hDEADBEEF,32'hF0F0};

    for (int i = 0; i < 13; i++) begin
      regwe = vecs[i].regwe; selwreg = vecs[i].selwreg; inA = vecs[i].ina;
      aluin = vecs[i].aluin; endwreg = vecs[i].endwreg; seloutA = vecs[i].sela;
      seloutB = vecs[i].selb; selcnstA = vecs[i].csa; selcnstB = vecs[i].csb;
      cnstA = vecs[i].ca; cnstB = vecs[i].cb; enrregA = vecs[i].ena; enrregB = vecs[i].enb;
      step();
      check($sformatf("vec%0d_outA", i), outA, vecs[i].exp_a);
      check($sformatf("vec%0d_outB", i), outB, vecs[i].exp_b);
      check($sformatf("vec%0d_outA_nz", i), outA_nz, vecs[i].exp_a_nz);
      check($sformatf("vec%0d_outB_nz", i), outB_nz, vecs[i].exp_b);
    end

    // Full clear: busy for 16 cycles, one clr_done, write during busy ignored.
    for (int r = 0; r < 16; r++) write_reg(4'(r), 32'h100 + r);
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    regwe = 1; endwreg = 4'd2; inA = 32'hBAD;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) regwe = 0;
      busy_cnt += int'(busy);
      done_cnt += int'(clr_done);
      step();
    end
    check("clear_busy_cycles", busy_cnt, 16);
    check("clear_done_pulses", done_cnt, 1);
    for (int r = 0; r < 16; r++) begin
      idle_inputs();
      seloutA = 4'(r); enrregA = 1;
      step();
      check($sformatf("cleared_r%0d", r), outA, '0);
      check($sformatf("cleared_nz_r%0d", r), outA_nz, '0);
    end

    // Reset asserted at clear cycle 6 aborts the clear without a done pulse.
    for (int r = 1; r < 16; r++) write_reg(4'(r), 32'h200 + r);
    idle_inputs();
    seloutA = 4'd7; enrregA = 1; selcnstB = 1; cnstB = 32'h5A; enrregB = 1;
    step();
    check("pre_abort_outA", outA, 32'h207);
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (6) step();
    check("pre_abort_busy", 32'(busy), 1);
    reset = 0;
    #1;
    check("abort_outA", outA, '0);
    check("abort_outB", outB, '0);
    check("abort_busy", 32'(busy), '0);
    check("abort_clr_done", 32'(clr_done), '0);
    repeat (2) begin
      step();
      check("abort_hold_clr_done", 32'(clr_done), '0);
    end
    reset = 1;
    for (int r = 6; r < 16; r++) begin
      idle_inputs();
      seloutA = 4'(r); seloutB = 4'(r); enrregA = 1; enrregB = 1;
      step();
      check($sformatf("abort_r%0d_A", r), outA, '0);
      check($sformatf("abort_r%0d_B", r), outB, '0);
    end
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    check("restart_busy", 32'(busy), 1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (clr_done) seen = 1;
      else step();
    end
    check("restart_clr_done_seen", 32'(seen), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
Parametrised register bank with two registered read ports, one write port, per-port constant injection, and a hardware clear sequencer. It feeds operands to the ALU and accepts either external data or the ALU result for write-back. It generalises the fixed 32-bit bank to configurable width and depth, adds an optional hardwired zero register, and adds a multi-cycle clear with a busy/done handshake.

Parameters:
WIDTH, 32, data width of registers, write data, constants and outputs
NREGS, 16, number of registers; must be a power of 2 and at least 2
AW, $clog2(NREGS), address width (derived; do not override)
ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
regwe  in  1  write enable
selwreg  in  1  write-data source: 0 = inA, 1 = aluin
inA  in  WIDTH  external write data
aluin  in  WIDTH  ALU result write data
endwreg  in  AW  write address
seloutA  in  AW  port A read address
seloutB  in  AW  port B read address
selcnstA  in  1  1 = port A loads cnstA instead of a register
selcnstB  in  1  1 = port B loads cnstB instead of a register
cnstA  in  WIDTH  port A constant
cnstB  in  WIDTH  port B constant
enrregA  in  1  port A output-register load enable
enrregB  in  1  port B output-register load enable
clr_req  in  1  start the clear sequence (level sampled in IDLE)
outA  out  WIDTH  registered port A operand
outB  out  WIDTH  registered port B operand
busy  out  1  high while the clear sequence runs
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0; outA = outB = 0
  - busy = 0; clr_done = 0; FSM = IDLE; clear counter = 0
  - reset mid-clear aborts the clear with no clr_done pulse
- Write (IDLE only):
  - on a rising edge with regwe=1: reg[endwreg] <= (selwreg ? aluin : inA)
  - if ZERO_R0=1 and endwreg=0, the write is dropped
- Read, port A (port B is identical):
  - on a rising edge with enrregA=1: outA <= selcnstA ? cnstA : reg[seloutA]
  - with enrregA=0, outA holds its value
  - one-cycle latency from address to output
  - reg[0] reads as 0 when ZERO_R0=1
- Read during write, macro off:
  - a read and a write to the same address in the same cycle returns the OLD value
  - the new value is visible on the following load
- FSM IDLE:
  - clr_req=1 -> CLEAR; counter = 0; busy <= 1
- FSM CLEAR:
  - each cycle: reg[counter] <= 0; counter++; regwe is ignored
  - when counter = NREGS-1: that register is cleared, then -> IDLE; busy <= 0; clr_done <= 1 for exactly one cycle
  - total busy time = NREGS cycles
- Reads during CLEAR:
  - output registers still load on their enables
  - values may be pre-clear or cleared, depending on the counter position
  - the bench must not check reads during CLEAR
- clr_req during CLEAR is ignored
- clr_req held high on the cycle clr_done pulses is sampled in IDLE on the next cycle and starts a new clear.
- Counter wrap: the counter is AW bits wide; it wraps naturally after NREGS-1, and the FSM exit is decoded from NREGS-1.

Optional Feature:
Macro REGBANK_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If regwe=1 in IDLE, the write is not dropped, and seloutX==endwreg with selcnstX=0 and enrregX=1, then outX loads the write data in the same edge.
  - Constant selection still takes priority over forwarding.
- Undefined: old-value semantics as described above.
- Neither setting affects CLEAR.

Test Plan:
1. Reset, then write inA=32'hDEADBEEF to r5 (selwreg=0), then seloutA=5 with enrregA=1 -> outA=32'hDEADBEEF one cycle after the load edge; outB stays 0.
2. selwreg=1, aluin=32'h00000123, write r0 with ZERO_R0=1 -> reading r0 gives 0. Repeat with ZERO_R0=0 -> reads 32'h123.
3. selcnstB=1, cnstB=32'h7, seloutB=5 -> outB=7. Then enrregB=0 while cnstB changes to 9 -> outB holds 7.
4. Fill r1..r15 with 32'h100+i, pulse clr_req -> busy high for exactly 16 cycles, clr_done pulses once at the end, all registers read 0. A regwe issued during busy has no effect.
5. Same-cycle write r3=32'hAA and read r3, with r3 previously 32'h55 -> outA=32'h55 with REGBANK_BYPASS_EN undefined, 32'hAA with it defined.
6. Drop reset to 0 at clear cycle 6 -> outputs are 0 immediately, busy=0, no clr_done pulse. After release, registers r6..r15 read 0 and the FSM accepts a new clr_req.
